// File: rtl/bg_scroll_fetch_pkg.sv
// Shared constants, state encoding and flash address arithmetic for the
// background scroll engine.
package bg_scroll_fetch_pkg;

  localparam int ROW_WORDS  = 8;     // 32-bit words per tile row
  localparam int PIC_ROWS   = 32;    // tile rows per picture
  localparam int NT_AW      = 9;     // nametable word address width
  localparam int PIC_BYTES  = 1024;  // one picture in flash
  localparam int ROW_BYTES  = 32;    // one tile row in flash
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_FREQ = 3'd2,
    ST_FWR  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Byte address of word w of row r of the picture after pic.
  // Offsets are built by concatenation: 1024 = 2^10, 32 = 2^5, 4 = 2^2.
  // The sum wraps at 24 bits.
  function automatic logic [23:0] row_word_addr(input logic [23:0] base,
                                                input logic [7:0]  pic,
                                                input logic [4:0]  row,
                                                input logic [2:0]  word);
    logic [8:0]  next_pic;
    logic [23:0] pic_off, row_off, word_off;
    next_pic = {1'b0, pic} + 9'd1;
    pic_off  = {5'd0, next_pic, 10'd0};
    row_off  = {14'd0, row, 5'd0};
    word_off = {19'd0, word, 2'd0};
    return base + pic_off + row_off + word_off;
  endfunction

endpackage

// File: rtl/bg_scroll_fetch_if.sv
// Flash read port and nametable write port of the scroll engine.
interface bg_scroll_fetch_if;
  import bg_scroll_fetch_pkg::*;

  logic             flash_req;
  logic [23:0]      flash_addr;
  logic             flash_ack;
  logic [31:0]      flash_rdata;
  logic             nt_wr_en;
  logic [NT_AW-1:0] nt_wr_addr;
  logic [31:0]      nt_wr_data;

  modport master (
    output flash_req, flash_addr, nt_wr_en, nt_wr_addr, nt_wr_data,
    input  flash_ack, flash_rdata
  );

  modport slave (
    input  flash_req, flash_addr, nt_wr_en, nt_wr_addr, nt_wr_data,
    output flash_ack, flash_rdata
  );
endinterface

// File: rtl/bg_scroll_fetch_row_fetcher.sv
// Copies one tile row (8 words) from flash into the nametable:
// FREQ holds the read request until ack, FWR writes the captured word.
module bg_row_fetcher
  import bg_scroll_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        abort_i,
  input  logic        start_i,
  input  logic [4:0]  row_i,
  input  logic [7:0]  pic_i,
  input  logic        half_i,
  input  logic [23:0] base_i,
  output logic        done_o,
  bg_scroll_fetch_if.master bus
);

  state_e           state_q;
  logic [2:0]       w_q;
  logic [4:0]       row_q;
  logic [7:0]       pic_q;
  logic             half_q;
  logic             req_q;
  logic [23:0]      addr_q;
  logic             wr_q;
  logic [NT_AW-1:0] wr_addr_q;
  logic [31:0]      data_q;

  // Last word being written; the top returns to RUN on this edge.
  assign done_o = (state_q == ST_FWR) && (w_q == 3'(ROW_WORDS - 1));

  assign bus.flash_req  = req_q;
  assign bus.flash_addr = addr_q;
  assign bus.nt_wr_en   = wr_q;
  assign bus.nt_wr_addr = wr_addr_q;
  assign bus.nt_wr_data = data_q;

  // Request/write sequencer; abort drops any outstanding request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      row_q     <= '0;
      pic_q     <= '0;
      half_q    <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      data_q    <= '0;
    end else begin
      wr_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_i) begin
            row_q   <= row_i;
            pic_q   <= pic_i;
            half_q  <= half_i;
            w_q     <= 3'd0;
            req_q   <= 1'b1;
            addr_q  <= row_word_addr(base_i, pic_i, row_i, 3'd0);
            state_q <= ST_FREQ;
          end
          ST_FREQ: if (bus.flash_ack) begin
            data_q    <= bus.flash_rdata;
            req_q     <= 1'b0;
            wr_q      <= 1'b1;
            wr_addr_q <= {half_q, row_q, w_q};
            state_q   <= ST_FWR;
          end
          ST_FWR: begin
            if (w_q == 3'(ROW_WORDS - 1)) begin
              state_q <= ST_IDLE;
            end else begin
              w_q     <= w_q + 3'd1;
              req_q   <= 1'b1;
              addr_q  <= row_word_addr(base_i, pic_q, row_q, w_q + 3'd1);
              state_q <= ST_FREQ;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/bg_scroll_fetch.sv
// Vertical background scroll engine: frame divider, scroll pointer and
// picture counter, and row prefetch into the hidden nametable half.
module bg_scroll_fetch
  import bg_scroll_fetch_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        frame_tick,
  input  logic        scrollEn,
  input  logic        scrollPause,
  input  logic [7:0]  scrollCntMax,
  input  logic [23:0] flashAddrStart,
  input  logic [7:0]  mapBackgroundMax,
  input  logic        createPlaneIntrEn,
  output logic [7:0]  mapBackgroundCnt,
  output logic [7:0]  mapScrollPtr,
  output logic        scrollingFlag,
  output logic        create_plane_irq,
  bg_scroll_fetch_if.master bus
);

  // The top only holds IDLE/RUN/FREQ/DONE; FREQ here covers the whole row
  // fetch, whose FREQ/FWR sub-phases live in the fetcher.
  state_e      state_q;
  logic [7:0]  ptr_q, cnt_q, div_q;
  logic        pend_q, scroll_q, irq_q;

  logic        tick_ok, div_match, step_go, last_pic, fetch_go, fetch_done;
  logic [7:0]  ptr_d, cnt_d;
  logic        irq_d;

  assign tick_ok   = frame_tick && !scrollPause;
  assign div_match = tick_ok && (div_q == scrollCntMax);
  // A deferred step and a fresh match in the same RUN cycle: one steps now,
  // the other stays pending.
  assign step_go   = (state_q == ST_RUN) && (div_match || pend_q);
  assign last_pic  = (ptr_q == 8'hFF) && (cnt_q == mapBackgroundMax);
  assign ptr_d     = ptr_q + 8'd1;
  assign cnt_d     = ((ptr_q == 8'hFF) && !last_pic) ? cnt_q + 8'd1 : cnt_q;
  assign irq_d     = createPlaneIntrEn && (ptr_d[4:0] == 5'd0);
  assign fetch_go  = step_go && !last_pic && (ptr_d[2:0] == 3'd0);

  assign mapScrollPtr     = ptr_q;
  assign mapBackgroundCnt = cnt_q;
  assign scrollingFlag    = scroll_q;
  assign create_plane_irq = irq_q;

  // Fetch the row that just came into view, for the next picture, into
  // the half of the nametable not currently displayed.
  bg_row_fetcher u_fetch (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .abort_i (!scrollEn),
    .start_i (fetch_go),
    .row_i   (ptr_d[7:3]),
    .pic_i   (cnt_d),
    .half_i  (~cnt_d[0]),
    .base_i  (flashAddrStart),
    .done_o  (fetch_done),
    .bus     (bus)
  );

  // Scroll FSM: divider, step, deferral of steps that land mid-fetch.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      pend_q   <= 1'b0;
      scroll_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (!scrollEn) begin
        state_q  <= ST_IDLE;
        ptr_q    <= '0;
        cnt_q    <= '0;
        div_q    <= '0;
        pend_q   <= 1'b0;
        scroll_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_RUN;
            scroll_q <= 1'b1;
            ptr_q    <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            pend_q   <= 1'b0;
          end
          ST_RUN: begin
            if (tick_ok) div_q <= div_match ? 8'd0 : div_q + 8'd1;
            if (step_go) begin
              ptr_q  <= ptr_d;
              cnt_q  <= cnt_d;
              irq_q  <= irq_d;
              pend_q <= pend_q && div_match;
              if (last_pic) begin
                state_q  <= ST_DONE;
                scroll_q <= 1'b0;
              end else if (fetch_go) begin
                state_q <= ST_FREQ;
              end
            end
          end
          ST_FREQ, ST_FWR: begin
            if (tick_ok) div_q <= div_match ? 8'd0 : div_q + 8'd1;
            if (div_match) pend_q <= 1'b1;
            if (fetch_done) state_q <= ST_RUN;
          end
          default: ;  // DONE: hold until scrollEn drops
        endcase
      end
    end
  end

endmodule
